// File: rtl/ikari_vreg_pkg.sv
// Shared types for the video-register write path: register selects,
// write-sequencer states and the address decode helper.
package ikari_vreg_pkg;

  localparam int VREG_NUM = 5;

  typedef enum logic [2:0] {
    VREG_BSET = 3'd0,
    VREG_SSET = 3'd1,
    VREG_MSET = 3'd2,
    VREG_F1SY = 3'd3,
    VREG_F2SY = 3'd4
  } vreg_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_ACK    = 2'd3
  } vreg_state_t;

  // Bit i of the result is the enable for register select i; selects 5-7 decode to nothing.
  function automatic logic [VREG_NUM-1:0] vreg_decode(input logic [2:0] addr);
    logic [VREG_NUM-1:0] sel;
    sel = '0;
    case (addr)
      VREG_BSET: sel[VREG_BSET] = 1'b1;
      VREG_SSET: sel[VREG_SSET] = 1'b1;
      VREG_MSET: sel[VREG_MSET] = 1'b1;
      VREG_F1SY: sel[VREG_F1SY] = 1'b1;
      VREG_F2SY: sel[VREG_F2SY] = 1'b1;
      default:   sel = '0;
    endcase
    return sel;
  endfunction

  function automatic logic vreg_addr_valid(input logic [2:0] addr);
    return addr <= VREG_F2SY;
  endfunction

endpackage

// File: rtl/ikari_rr_arb2.sv
// Two-input round-robin arbiter. Grant is combinational and only offered
// while en is high; the last winner is remembered so ties alternate.
module ikari_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_b;  // 1: requester B (index 1) won the previous grant

  always_comb begin
    // NOTE: default first so no path through this block leaves grant unassigned (no latch).
    grant = '0;
    if (en) begin
      if (req[0] && req[1]) begin
        grant = last_b ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      last_b <= 1'b1;
    end else if (|grant) begin
      last_b <= grant[1];
    end
  end

endmodule

// File: rtl/ikari_vreg_write_arbiter.sv
// Main/sub CPU video-register write arbiter: grants one write, drives VD_out,
// issues a one-cycle register strobe one cycle later, then acknowledges.
module ikari_vreg_write_arbiter
  import ikari_vreg_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [2:0] addr_a,
  input  logic [2:0] addr_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       err_a,
  output logic       err_b,
  output logic [7:0] VD_out,
  output logic       BSET,
  output logic       SSET,
  output logic       MSET,
  output logic       F1SY,
  output logic       F2SY,
  output logic       busy
);

  vreg_state_t         state_q, state_d;
  logic [NREQ-1:0]     req, grant;
  logic [2:0]          addr_q;
  logic                win_b_q;
  logic [VREG_NUM-1:0] strobe_d, strobe_q;
  logic                ack_a_d, ack_b_d, err_d;

  assign req = {req_b, req_a};

  ikari_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_IDLE),
    .req   (req),
    .grant (grant)
  );

  always_comb begin
    state_d  = state_q;
    strobe_d = '0;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE:   if (|grant) state_d = ST_SETUP;
      ST_SETUP: begin
        state_d  = ST_STROBE;
        strobe_d = vreg_decode(addr_q);
      end
      ST_STROBE: begin
        state_d = ST_ACK;
        ack_a_d = !win_b_q;
        ack_b_d = win_b_q;
        err_d   = !vreg_addr_valid(addr_q);
      end
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Every output is a flop; the strobe/ack values computed above land one edge later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      strobe_q <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      err_a    <= 1'b0;
      err_b    <= 1'b0;
      busy     <= 1'b0;
      VD_out   <= 8'h00;
      addr_q   <= 3'd0;
      win_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
      ack_a    <= ack_a_d;
      ack_b    <= ack_b_d;
      err_a    <= ack_a_d & err_d;
      err_b    <= ack_b_d & err_d;
      busy     <= (state_d != ST_IDLE);
      if (|grant) begin
        win_b_q <= grant[1];
        addr_q  <= grant[1] ? addr_b : addr_a;
        VD_out  <= grant[1] ? data_b : data_a;
      end
    end
  end

  assign BSET = strobe_q[VREG_BSET];
  assign SSET = strobe_q[VREG_SSET];
  assign MSET = strobe_q[VREG_MSET];
  assign F1SY = strobe_q[VREG_F1SY];
  assign F2SY = strobe_q[VREG_F2SY];

endmodule

// File: tb/tb_ikari_vreg_write_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grant order and the
// cycle of each strobe/ack; a negedge monitor pops and compares.
module tb_ikari_vreg_write_arbiter;

  logic       clk;
  logic       reset;
  logic       req_a, req_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b, err_a, err_b;
  logic [7:0] VD_out;
  logic       BSET, SSET, MSET, F1SY, F2SY, busy;

  ikari_vreg_write_arbiter #(.NREQ(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .req_a  (req_a),
    .req_b  (req_b),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .data_a (data_a),
    .data_b (data_b),
    .ack_a  (ack_a),
    .ack_b  (ack_b),
    .err_a  (err_a),
    .err_b  (err_b),
    .VD_out (VD_out),
    .BSET   (BSET),
    .SSET   (SSET),
    .MSET   (MSET),
    .F1SY   (F1SY),
    .F2SY   (F2SY),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Event vector: {F2SY,F1SY,MSET,SSET,BSET, ack_a,err_a, ack_b,err_b}
  typedef struct {
    int         cyc;
    logic [8:0] vec;
  } ev_t;
  ev_t sb[$];

  bit         m_last_b = 1'b1;
  int         m_free_at = 0;
  int         m_grant_cyc = -100;
  logic [7:0] m_vd = 8'h00;
  bit         m_win_b;
  logic [2:0] m_addr;
  bit         m_bad;

  always @(posedge clk) begin
    if (!reset) begin
      sb.delete();
      m_last_b    = 1'b1;
      m_free_at   = cyc + 1;
      m_grant_cyc = cyc;
      m_vd        = 8'h00;
    end else if (cyc >= m_free_at && (req_a || req_b)) begin
      m_win_b     = (req_a && req_b) ? !m_last_b : req_b;
      m_addr      = m_win_b ? addr_b : addr_a;
      m_vd        = m_win_b ? data_b : data_a;
      m_bad       = (m_addr > 3'd4);
      m_last_b    = m_win_b;
      m_grant_cyc = cyc;
      m_free_at   = cyc + 4;
      if (!m_bad) sb.push_back('{cyc + 2, {5'(32'd1 << m_addr), 4'b0000}});
      sb.push_back('{cyc + 3, {5'b00000, !m_win_b, !m_win_b && m_bad, m_win_b, m_win_b && m_bad}});
    end
    cyc = cyc + 1;
  end

  logic [8:0] obs;
  always @(negedge clk) begin
    obs = {F2SY, F1SY, MSET, SSET, BSET, ack_a, err_a, ack_b, err_b};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("event_missed", 32'(cyc), 32'(sb[0].cyc));
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      check("strobe_ack", 32'(obs), 32'(sb[0].vec));
      void'(sb.pop_front());
    end else if (obs != 9'd0) begin
      check("unexpected_out", 32'(obs), 32'd0);
    end
    check("vd_out", 32'(VD_out), 32'(m_vd));
    check("busy", 32'(busy), 32'(cyc > m_grant_cyc && cyc < m_free_at));
  end

  // ---------------- requester driver ----------------
  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         gap;
    int         mut;
  } item_t;
  item_t iq[2][$];

  logic       rq[2];
  logic [2:0] ad[2];
  logic [7:0] dt[2];
  int         mut_cnt[2];

  assign req_a  = rq[0];
  assign req_b  = rq[1];
  assign addr_a = ad[0];
  assign addr_b = ad[1];
  assign data_a = dt[0];
  assign data_b = dt[1];

  task automatic push(input int r, input logic [2:0] a, input logic [7:0] d, input int gap, input int mut);
    iq[r].push_back('{a, d, gap, mut});
  endtask

  // One negedge of requester behaviour: drop on ack, late data change, load next.
  task automatic drive_cycle();
    logic  ackd;
    item_t it;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      ackd = (r == 0) ? ack_a : ack_b;
      if (rq[r] && ackd) rq[r] = 1'b0;
      if (rq[r] && mut_cnt[r] > 0) begin
        mut_cnt[r]--;
        if (mut_cnt[r] == 0) dt[r] = ~dt[r];
      end
      if (!rq[r] && iq[r].size() > 0) begin
        if (iq[r][0].gap > 0) begin
          iq[r][0].gap--;
        end else begin
          it         = iq[r].pop_front();
          ad[r]      = it.addr;
          dt[r]      = it.data;
          mut_cnt[r] = it.mut;
          rq[r]      = 1'b1;
        end
      end
    end
  endtask

  task automatic drain(input bit rand_rst);
    int n;
    n = 0;
    while ((iq[0].size() > 0 || iq[1].size() > 0 || rq[0] || rq[1]) && n < 2000) begin
      drive_cycle();
      n++;
      if (!reset) reset = 1'b1;
      else if (rand_rst && $urandom_range(0, 149) == 0) reset = 1'b0;
    end
    reset = 1'b1;
    check("drain_done", 32'(n >= 2000), 32'd0);
    repeat (3) drive_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      rq[r] = 1'b0; ad[r] = 3'd0; dt[r] = 8'h00; mut_cnt[r] = 0;
    end
    repeat (3) drive_cycle();
    reset = 1'b1;
    repeat (2) drive_cycle();

    // Single write to F1SY
    push(0, 3'd3, 8'h5A, 0, 0);
    drain(0);

    // Simultaneous pairs to BSET
    push(0, 3'd0, 8'h11, 0, 0); push(1, 3'd0, 8'h22, 0, 0);
    drain(0);
    push(0, 3'd0, 8'h33, 0, 0); push(1, 3'd0, 8'h44, 0, 0);
    drain(0);
    push(0, 3'd1, 8'h55, 0, 0);
    drain(0);
    push(0, 3'd0, 8'h66, 0, 0); push(1, 3'd0, 8'h77, 0, 0);
    drain(0);

    // Invalid address from B
    push(1, 3'd6, 8'($urandom), 0, 0);
    drain(0);

    // Data changes one cycle after grant
    push(0, 3'd2, 8'hF0, 0, 1);
    drain(0);

    // Reset asserted while the strobe is high; req_a stays held
    push(0, 3'd1, 8'h3C, 0, 0);
    drive_cycle();
    drive_cycle();
    drive_cycle();
    reset = 1'b0;
    drive_cycle();
    reset = 1'b1;
    drain(0);

    // Back-to-back writes from A across every register
    for (int i = 0; i < 5; i++) push(0, 3'(i), 8'($urandom), 0, 0);
    drain(0);

    // Randomized traffic from both CPUs, with occasional resets
    for (int i = 0; i < 60; i++) begin
      push($urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom),
           $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end
    drain(1);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ikari_vreg_write_arbiter.md
# ikari_vreg_write_arbiter

Arbitrates video-register writes from the main and sub CPUs onto the shared VD data bus. Decodes each write into a one-cycle strobe on BSET, SSET, MSET, F1SY or F2SY and sequences it against the register bank's one-cycle VD input pipeline. Sits between the two CPU bus interfaces and the video register bank in the video core.

## Interface
Parameters:
- NREQ, 2, number of requesters (fixed at 2; A = main CPU, B = sub CPU)

Ports:
- clk  in  1  video core clock
- reset  in  1  synchronous, active-low reset
- req_a, req_b  in  1  write request; held high until matching ack
- addr_a, addr_b  in  3  register select: 0 BSET, 1 SSET, 2 MSET, 3 F1SY, 4 F2SY, 5–7 invalid
- data_a, data_b  in  8  write data
- ack_a, ack_b  out  1  one-cycle completion pulse
- err_a, err_b  out  1  qualifies ack: invalid address, no strobe issued
- VD_out  out  8  data to the register bank VD_in
- BSET, SSET, MSET, F1SY, F2SY  out  1  one-hot, one-cycle register enables
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, SETUP, STROBE, ACK.
- IDLE:
  - Selects a winner among asserted requests.
  - Latches the winner's addr and data.
  - Drives VD_out from the latched data.
  - Moves to SETUP.
- SETUP → STROBE: asserts the decoded strobe. An invalid address asserts no strobe.
- STROBE → ACK:
  - Deasserts the strobe.
  - Pulses the winner's ack, and err if the address was invalid.
- ACK → IDLE unconditionally.
- Arbitration is round-robin:
  - last_grant toggles to the winner on every grant.
  - With both requesting, the requester not granted last wins.
  - After reset, A has priority.
- A requester whose req is still high in the IDLE cycle after its ack is treated as a new request.
- addr and data are sampled only at grant. Changes after grant are ignored.
- VD_out holds its last value in all states. It changes only on a grant.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Reset values:
  - All strobes, acks, errs and busy = 0.
  - VD_out = 0x00.
  - State = IDLE; last_grant = B (so A wins first).
- Cycle numbering, with req seen in IDLE at cycle 0:
  - Cycle 1: VD_out valid; busy = 1.
  - Cycle 2: strobe high. The register bank captures its delayed copy of VD_out at the end of cycle 2.
  - Cycle 3: ack high.
  - Cycle 4: IDLE.
- Latency from req to ack is 3 cycles. Maximum throughput is 1 write per 4 cycles.
- VD_out must be stable from cycle 1 through cycle 2. This is guaranteed because it changes only at a grant.
- Exactly one strobe is high per valid write. No strobe is high outside STROBE.
- A request arriving while busy waits. It is evaluated in the next IDLE cycle.
- Reset mid-operation:
  - Returns to reset values on the next edge.
  - Any in-flight strobe or ack is suppressed.
  - The interrupted requester is not acked. Its held req is re-arbitrated after reset.
- Simultaneous req_a and req_b in IDLE: exactly one grant, per round-robin. The loser is served in the next IDLE cycle (cycle 4).

## Structure
- Package ikari_vreg_pkg holds:
  - enum vreg_sel_t {VREG_BSET=0, VREG_SSET, VREG_MSET, VREG_F1SY, VREG_F2SY}.
  - FSM state enum.
  - VREG_NUM = 5.
- Sub-module ikari_rr_arb2: 2-input round-robin arbiter with last_grant register and a grant-enable input.
- Top level holds the FSM, latches, decode and output registers.

## Test plan
- Reset release, then req_a with addr 3 and data 0x5A:
  - VD_out = 0x5A at cycle 1.
  - F1SY high only in cycle 2.
  - ack_a at cycle 3, err_a = 0.
- req_a and req_b asserted together, both with addr 0, data 0x11 and 0x22:
  - A served first (BSET with 0x11).
  - B granted at cycle 4, BSET with 0x22 at cycle 6.
  - A third simultaneous pair is served B first.
- req_b with addr 6:
  - No strobe in any cycle.
  - ack_b and err_b both high at cycle 3.
  - VD_out = data_b.
- req_a with addr 2 and data 0xF0, then data_a changed to 0x0F at cycle 1: VD_out stays 0xF0 through cycle 2, MSET high at cycle 2.
- reset asserted during STROBE: outputs at reset values next cycle, no ack_a. After release, a held req_a completes normally.
- Back-to-back req_a held high across 5 writes, cycling addr 0–4: one-hot strobes at cycles 2, 6, 10, 14, 18, with no overlap.
